minimax_rf_wb: RTL
==================

MINIMAX_RF_WB -- requirements
Module: minimax_rf_wb

Interface
REQ-001 SHALL have no parameters; width is fixed at 32 bits and there are 32 registers.
REQ-002 SHALL use one clock and an asynchronous, active-low reset. Ports:
CLK  in  1  clock; all state updates on posedge
RST_N  in  1  asynchronous active-low reset
alu_we  in  1  ALU result valid this cycle
alu_rd  in  5  ALU destination
alu_data  in  32  ALU result
ld_issue  in  1  load issued to memory this cycle
ld_issue_rd  in  5  load destination
ld_issue_fmt  in  3  load funct3
ld_issue_off  in  2  byte address[1:0]
ld_rvalid  in  1  load response valid
ld_rdata  in  32  raw memory word
dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage operands
stall  out  1  decode must hold
ld_busy  out  1  load outstanding or held
rf_we  out  4  byte write enables to register file port 0
rf_a0  out  5  port-0 address (write or rs1 read)
rf_a1  out  5  port-1 read address
rf_di  out  32  write data
rf_do0, rf_do1  in  32 each  register file read data
rs1_data, rs2_data  out  32 each  operand data to execute

Function
REQ-003 SHALL implement states IDLE, WAIT (load outstanding) and HOLD (aligned load data registered, awaiting write).
REQ-004 IDLE + ld_issue SHALL capture rd, fmt and off, and move to WAIT; ld_issue outside IDLE is a protocol error and is ignored.
REQ-005 WAIT + ld_rvalid SHALL register the aligned data and move to HOLD one cycle later; ld_rvalid in IDLE/HOLD is ignored.
REQ-006 Alignment SHALL be: 000 LB = byte[off] sign-extended; 001 LH = half[off[1]] sign-extended; 100 LBU / 101 LHU = zero-extended; 010 and all other codes = full word; off[0] is ignored for halves and off is ignored for words.
REQ-007 Port-0 write owner priority SHALL be alu_we first, then HOLD.
- If alu_we is high in HOLD, the ALU writes and the load remains in HOLD.
- Otherwise HOLD writes the load result and moves to IDLE.
REQ-008 Writes to rd=0 SHALL drive rf_we=0 while still consuming the HOLD entry; valid writes drive rf_we=4'hF.
REQ-009 rf_a0 SHALL be the write rd when a write is active, else dec_rs1; rf_a1 SHALL always be dec_rs2.
REQ-010 rs1_data SHALL be:
- 0 when dec_rs1=0;
- alu_data when an ALU write is active and dec_rs1=alu_rd;
- otherwise rf_do0.
REQ-011 rs2_data SHALL be:
- 0 when dec_rs2=0;
- the active write data when dec_rs2 matches the active write rd;
- otherwise rf_do1.
REQ-012 stall SHALL be the combinational OR of:
- state≠IDLE and pending rd≠0 and pending rd ∈ {dec_rs1, dec_rs2, dec_rd} (RAW/WAW);
- state=HOLD;
- a port-0 write is active and dec_rs1≠0 and dec_rs1≠the write rd.
REQ-013 ld_busy SHALL equal (state≠IDLE).
REQ-014 ld_rvalid and ld_issue in the same WAIT cycle SHALL complete the old load only; the new issue is ignored.

Reset
REQ-015 While RST_N=0:
- state=IDLE;
- pending rd/fmt/off and held data = 0;
- rf_we=0, stall=0, ld_busy=0.
REQ-016 Reset asserted mid-load SHALL discard the pending load with no register-file write; a late ld_rvalid after reset is ignored.

Structure
REQ-017 Load funct3 codes, the state enum and the XLEN=32 constant SHALL live in shared package minimax_pkg.
REQ-018 Load alignment SHALL be the combinational sub-module minimax_load_align (inputs: fmt, off, word; output: 32-bit result).

Verification
REQ-019 LB, off=3, ld_rdata=32'h80FF_0000, rd=5 -> after HOLD, x5 written 32'hFFFF_FF80 with rf_we=4'hF, then ld_busy=0.
REQ-020 LHU, off=2, rdata=32'hBEEF_1234, rd=7, with dec_rs1=7 during WAIT -> stall=1 through HOLD, x7=32'h0000_BEEF, and stall drops the cycle after the write.
REQ-021 HOLD concurrent with alu_we (rd=3, data=32'h11) -> ALU writes x3 first, the load writes next cycle, and no write is lost.
REQ-022 Load to rd=0 -> rf_we stays 0, the state returns to IDLE, and rs1_data=0 for dec_rs1=0.
REQ-023 RST_N pulsed low in WAIT, followed by ld_rvalid -> no write, state=IDLE, all outputs at reset values.
REQ-024 ALU write to rd=9 with dec_rs2=9 -> rs2_data=alu_data the same cycle, and stall=0 when dec_rs1∈{0,9}.

Source files
------------

// File: rtl/minimax_pkg.sv
// Shared constants, load funct3 codes and the write-back FSM state type
// for the minimax register-file write-back block.
package minimax_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } ld_state_e;

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
    ext8 = {{(XLEN-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
    ext16 = {{(XLEN-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/minimax_load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by the
// load offset out of the raw memory word and sign- or zero-extends it.
module minimax_load_align
  import minimax_pkg::*;
(
  input  logic [2:0]      fmt,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection; off[0] is irrelevant for halfword loads
  always_comb begin
    case (off)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    if (off[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extension by funct3; unknown codes load the full word
  always_comb begin
    case (fmt)
      F3_LB:   result = ext8(byte_s, 1'b1);
      F3_LH:   result = ext16(half_s, 1'b1);
      F3_LBU:  result = ext8(byte_s, 1'b0);
      F3_LHU:  result = ext16(half_s, 1'b0);
      default: result = word;
    endcase
  end

endmodule

// File: rtl/minimax_rf_wb.sv
// Register-file write-back arbiter: shares port 0 between ALU results and a
// single outstanding load, forwards operands and raises decode stalls.
module minimax_rf_wb
  import minimax_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            alu_we,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic [2:0]      ld_issue_fmt,
  input  logic [1:0]      ld_issue_off,
  input  logic            ld_rvalid,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            stall,
  output logic            ld_busy,
  output logic [3:0]      rf_we,
  output logic [4:0]      rf_a0,
  output logic [4:0]      rf_a1,
  output logic [XLEN-1:0] rf_di,
  input  logic [XLEN-1:0] rf_do0,
  input  logic [XLEN-1:0] rf_do1,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  ld_state_e       state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      fmt_q, fmt_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] data_q, data_d;

  logic [XLEN-1:0] aligned_s;
  logic            hold_wr_s;
  logic            wr_act_s;
  logic [4:0]      wr_rd_s;
  logic [XLEN-1:0] wr_data_s;
  logic            dep_s;

  minimax_load_align u_align (
    .fmt    (fmt_q),
    .off    (off_q),
    .word   (ld_rdata),
    .result (aligned_s)
  );

  // Load tracking state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      rd_q    <= 5'd0;
      fmt_q   <= 3'd0;
      off_q   <= 2'd0;
      data_q  <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      fmt_q   <= fmt_d;
      off_q   <= off_d;
      data_q  <= data_d;
    end
  end

  // Next state: one load in flight; a response in WAIT wins over a new issue
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    fmt_d   = fmt_q;
    off_d   = off_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (ld_issue) begin
          rd_d    = ld_issue_rd;
          fmt_d   = ld_issue_fmt;
          off_d   = ld_issue_off;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (ld_rvalid) begin
          data_d  = aligned_s;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (alu_we) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Port-0 ownership, operand bypass and stall generation
  always_comb begin
    hold_wr_s = (state_q == HOLD) && !alu_we;
    wr_act_s  = RST_N && (alu_we || hold_wr_s);
    if (alu_we) begin
      wr_rd_s   = alu_rd;
      wr_data_s = alu_data;
    end else begin
      wr_rd_s   = rd_q;
      wr_data_s = data_q;
    end

    if (wr_act_s && (wr_rd_s != 5'd0)) begin
      rf_we = 4'hF;
    end else begin
      rf_we = 4'h0;
    end
    rf_a0 = wr_act_s ? wr_rd_s : dec_rs1;
    rf_a1 = dec_rs2;
    rf_di = wr_data_s;

    if (dec_rs1 == 5'd0) begin
      rs1_data = {XLEN{1'b0}};
    end else if (wr_act_s && alu_we && (dec_rs1 == alu_rd)) begin
      rs1_data = alu_data;
    end else begin
      rs1_data = rf_do0;
    end

    if (dec_rs2 == 5'd0) begin
      rs2_data = {XLEN{1'b0}};
    end else if (wr_act_s && (dec_rs2 == wr_rd_s)) begin
      rs2_data = wr_data_s;
    end else begin
      rs2_data = rf_do1;
    end

    // Port 0 busy writing means rs1 cannot be read unless it is bypassed
    dep_s   = (state_q != IDLE) && (rd_q != 5'd0) &&
              ((rd_q == dec_rs1) || (rd_q == dec_rs2) || (rd_q == dec_rd));
    stall   = RST_N && (dep_s || (state_q == HOLD) ||
              (wr_act_s && (dec_rs1 != 5'd0) && (dec_rs1 != wr_rd_s)));
    ld_busy = (state_q != IDLE);
  end

endmodule
